bip_control_unit: RTL and testbench
===================================

// Module: bip_control_unit
// PURPOSE
//  Sequencer for the accumulator CPU. Drives the program-memory address (PC),
//  decodes each 16-bit instruction word (5-bit opcode, 11-bit operand) and issues
//  single-cycle control strobes to the accumulator datapath and data RAM.
//  Sits between program memory and datapath; start/halt status and cycle count go to the debug/UART unit.
// PARAMETERS
//  addr_bus   11  PC / operand width; program memory depth is 2**addr_bus
//  data_size  16  instruction word width; opcode = Instr[data_size-1 -: 5]
//  cnt_width  16  width of Cycle_Count
// PORTS
//  Clk          in   1          clock; all state updates on rising edge
//  Reset        in   1          synchronous, active-high reset
//  Start        in   1          level/pulse; starts execution from IDLE
//  Instr        in   data_size  instruction word from program memory (combinational read of Pc_Addr)
//  Pc_Addr      out  addr_bus   program counter -> program memory Addr
//  Operand      out  addr_bus   Instr[addr_bus-1:0]; RAM address or immediate
//  Sel_A        out  2          acc source: 0=RAM data, 1=immediate, 2=ALU result
//  Sel_B        out  1          ALU operand B: 0=RAM data, 1=immediate
//  Alu_Op       out  1          0=add, 1=sub
//  Wr_Acc       out  1          accumulator write enable
//  Wr_Ram       out  1          data RAM write (acc -> RAM[Operand])
//  Rd_Ram       out  1          data RAM read enable
//  Running      out  1          1 while in RUN
//  Done         out  1          1 while in HALTED (sticky until Reset)
//  Cycle_Count  out  cnt_width  clocks spent in RUN
// BEHAVIOUR
//  - FSM: IDLE -> RUN (Start=1) ; RUN -> HALTED (opcode HLT) ; HALTED stays until Reset.
//    Start ignored in RUN and HALTED.
//  - Reset (any state, incl. mid-program): state=IDLE, PC=0, Cycle_Count=0 on the next edge;
//    Running=Done=0, all strobes 0. Operand always follows Instr.
//  - Strobes are combinational from Instr, gated by state==RUN; outside RUN all strobes 0,
//    Sel_A=0, Sel_B=0, Alu_Op=0.
//  - One instruction per clock in RUN; latency Start->first strobe = 1 clock (IDLE->RUN edge).
//  - Decode (unlisted signals 0):
//      HLT  00000: no strobes; PC holds; next state HALTED
//      STO  00001: Wr_Ram
//      LD   00010: Rd_Ram, Sel_A=0, Wr_Acc
//      LDI  00011: Sel_A=1, Wr_Acc
//      ADD  00100: Rd_Ram, Sel_A=2, Sel_B=0, Alu_Op=0, Wr_Acc
//      ADDI 00101: Sel_A=2, Sel_B=1, Alu_Op=0, Wr_Acc
//      SUB  00110: Rd_Ram, Sel_A=2, Sel_B=0, Alu_Op=1, Wr_Acc
//      SUBI 00111: Sel_A=2, Sel_B=1, Alu_Op=1, Wr_Acc
//      01000..11111: NOP (no strobes, PC advances)
//  - PC: in RUN, non-HLT -> PC+1 modulo 2**addr_bus (wraps 2**addr_bus-1 -> 0); IDLE/HALTED hold.
//  - Cycle_Count: +1 every clock in RUN, including the HLT cycle; saturates at 2**cnt_width-1.
//  - Reset asserted with Start in the same cycle: Reset wins (IDLE).
// STRUCTURE
//  - Shared include bip_defs.vh: opcode localparams (HLT..SUBI), Sel_A encodings,
//    Alu_Op encodings, FSM state encodings (IDLE=0, RUN=1, HALTED=2).
//  - One sub-module: bip_decoder (combinational opcode -> Sel_A/Sel_B/Alu_Op/Wr_Acc/Wr_Ram/Rd_Ram/is_hlt).
//    Top holds FSM, PC, cycle counter and RUN gating.
// TESTING
//  1. Reset held 3 clocks then released, Start=0 for 5 clocks -> Pc_Addr=0, Running=0, Done=0,
//     strobes 0, Cycle_Count=0.
//  2. Program LDI 16; STO 1; LD 1; ADDI 255; STO 2; LD 16; HLT, pulse Start ->
//     Pc_Addr 0..6 on consecutive clocks; strobes per table; HALTED with Pc_Addr=6,
//     Done=1, Cycle_Count=7; state held 10 more clocks.
//  3. Opcode 5'b11111 at PC=0 then HLT -> no strobes at PC=0, PC advances to 1, halts
//     with Cycle_Count=2.
//  4. Memory all NOP except HLT at address 0, started from PC=2047 by forcing PC
//     (addr_bus=11) -> PC wraps 2047->0 and halts at 0.
//  5. Reset asserted at PC=3 mid-program -> next clock IDLE, PC=0, Cycle_Count=0, strobes 0;
//     Start reruns program from 0 to identical results.
//  6. Start pulsed in RUN and in HALTED -> no effect on PC or state; cnt_width=3 with 10-NOP
//     program -> Cycle_Count saturates at 7.

Source files
------------

// File: rtl/bip_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bip_control_unit_pkg
//  Description : Shared definitions for the accumulator-CPU control unit.
//                Holds the opcode values, the Sel_A and Alu_Op encodings and
//                the FSM state encoding used by the decoder and the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package bip_control_unit_pkg;

    // Width of the opcode field at the top of the instruction word
    localparam int c_OPC_W = 5;

    // Opcodes; everything from 5'b01000 upward executes as a NOP
    localparam logic [c_OPC_W-1:0] c_OP_HLT  = 5'b00000;
    localparam logic [c_OPC_W-1:0] c_OP_STO  = 5'b00001;
    localparam logic [c_OPC_W-1:0] c_OP_LD   = 5'b00010;
    localparam logic [c_OPC_W-1:0] c_OP_LDI  = 5'b00011;
    localparam logic [c_OPC_W-1:0] c_OP_ADD  = 5'b00100;
    localparam logic [c_OPC_W-1:0] c_OP_ADDI = 5'b00101;
    localparam logic [c_OPC_W-1:0] c_OP_SUB  = 5'b00110;
    localparam logic [c_OPC_W-1:0] c_OP_SUBI = 5'b00111;

    // Accumulator source select
    localparam logic [1:0] c_SEL_A_RAM = 2'd0;
    localparam logic [1:0] c_SEL_A_IMM = 2'd1;
    localparam logic [1:0] c_SEL_A_ALU = 2'd2;

    // ALU operand-B select
    localparam logic c_SEL_B_RAM = 1'b0;
    localparam logic c_SEL_B_IMM = 1'b1;

    // ALU operation
    localparam logic c_ALU_ADD = 1'b0;
    localparam logic c_ALU_SUB = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage : bip_control_unit_pkg
`default_nettype wire

// File: rtl/bip_control_unit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bip_decoder
//  Description : Purely combinational opcode decoder. Produces the raw
//                datapath controls for one instruction; gating by the
//                sequencer state is done in the top level.
//  Ports       : i_opcode  - 5-bit opcode field
//                o_sel_a   - accumulator source (RAM / immediate / ALU)
//                o_sel_b   - ALU operand B (RAM / immediate)
//                o_alu_op  - add / subtract
//                o_wr_acc  - accumulator write
//                o_wr_ram  - data RAM write
//                o_rd_ram  - data RAM read
//                o_is_hlt  - instruction is HLT
//  Revision    : 1.0  initial release
// ============================================================================
module bip_decoder
    import bip_control_unit_pkg::*;
(
    input  logic [c_OPC_W-1:0] i_opcode,
    output logic [1:0]         o_sel_a,
    output logic               o_sel_b,
    output logic               o_alu_op,
    output logic               o_wr_acc,
    output logic               o_wr_ram,
    output logic               o_rd_ram,
    output logic               o_is_hlt
);

    always_comb begin
        o_sel_a  = c_SEL_A_RAM;
        o_sel_b  = c_SEL_B_RAM;
        o_alu_op = c_ALU_ADD;
        o_wr_acc = 1'b0;
        o_wr_ram = 1'b0;
        o_rd_ram = 1'b0;
        o_is_hlt = 1'b0;

        case (i_opcode)
            c_OP_HLT: begin
                o_is_hlt = 1'b1;
            end
            c_OP_STO: begin
                o_wr_ram = 1'b1;
            end
            c_OP_LD: begin
                o_rd_ram = 1'b1;
                o_sel_a  = c_SEL_A_RAM;
                o_wr_acc = 1'b1;
            end
            c_OP_LDI: begin
                o_sel_a  = c_SEL_A_IMM;
                o_wr_acc = 1'b1;
            end
            c_OP_ADD: begin
                o_rd_ram = 1'b1;
                o_sel_a  = c_SEL_A_ALU;
                o_sel_b  = c_SEL_B_RAM;
                o_alu_op = c_ALU_ADD;
                o_wr_acc = 1'b1;
            end
            c_OP_ADDI: begin
                o_sel_a  = c_SEL_A_ALU;
                o_sel_b  = c_SEL_B_IMM;
                o_alu_op = c_ALU_ADD;
                o_wr_acc = 1'b1;
            end
            c_OP_SUB: begin
                o_rd_ram = 1'b1;
                o_sel_a  = c_SEL_A_ALU;
                o_sel_b  = c_SEL_B_RAM;
                o_alu_op = c_ALU_SUB;
                o_wr_acc = 1'b1;
            end
            c_OP_SUBI: begin
                o_sel_a  = c_SEL_A_ALU;
                o_sel_b  = c_SEL_B_IMM;
                o_alu_op = c_ALU_SUB;
                o_wr_acc = 1'b1;
            end
            default: begin
                // Unassigned opcodes are NOPs: no strobes, PC still advances
            end
        endcase
    end

endmodule : bip_decoder
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bip_control_unit
//  Description : Sequencer for the accumulator CPU. Owns the program counter,
//                the IDLE/RUN/HALTED state machine and the RUN cycle counter;
//                issues one instruction per clock while running.
//  Ports       : Clk, Reset (sync, active high), Start
//                Instr       - word read combinationally at Pc_Addr
//                Pc_Addr     - program counter
//                Operand     - low ADDR_BUS bits of Instr
//                Sel_A/Sel_B/Alu_Op/Wr_Acc/Wr_Ram/Rd_Ram - datapath strobes
//                Running/Done - state status, Cycle_Count - clocks in RUN
//  Revision    : 1.0  initial release
// ============================================================================
module bip_control_unit
    import bip_control_unit_pkg::*;
#(
    parameter int ADDR_BUS  = 11,
    parameter int DATA_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [DATA_SIZE-1:0] Instr,
    output logic [ADDR_BUS-1:0]  Pc_Addr,
    output logic [ADDR_BUS-1:0]  Operand,
    output logic [1:0]           Sel_A,
    output logic                 Sel_B,
    output logic                 Alu_Op,
    output logic                 Wr_Acc,
    output logic                 Wr_Ram,
    output logic                 Rd_Ram,
    output logic                 Running,
    output logic                 Done,
    output logic [CNT_WIDTH-1:0] Cycle_Count
);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_BUS-1:0]   r_pc;
    logic [ADDR_BUS-1:0]   w_next_pc;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_next_cnt;

    logic [1:0]            w_dec_sel_a;
    logic                  w_dec_sel_b;
    logic                  w_dec_alu_op;
    logic                  w_dec_wr_acc;
    logic                  w_dec_wr_ram;
    logic                  w_dec_rd_ram;
    logic                  w_dec_is_hlt;
    logic                  w_run;

    bip_decoder u_decoder (
        .i_opcode (Instr[DATA_SIZE-1 -: c_OPC_W]),
        .o_sel_a  (w_dec_sel_a),
        .o_sel_b  (w_dec_sel_b),
        .o_alu_op (w_dec_alu_op),
        .o_wr_acc (w_dec_wr_acc),
        .o_wr_ram (w_dec_wr_ram),
        .o_rd_ram (w_dec_rd_ram),
        .o_is_hlt (w_dec_is_hlt)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_cnt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // The HLT cycle itself is a RUN clock and is counted
                if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                    w_next_cnt = r_cnt + CNT_WIDTH'(1);
                end
                if (w_dec_is_hlt) begin
                    w_next_state = ST_HALTED;
                end else begin
                    // Natural wrap from the last address back to 0
                    w_next_pc = r_pc + ADDR_BUS'(1);
                end
            end
            ST_HALTED: begin
                // Sticky until Reset; Start is ignored
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_run = (r_state == ST_RUN);

    // Strobes are only meaningful while executing; elsewhere drive neutral
    always_comb begin
        Sel_A  = w_run ? w_dec_sel_a  : c_SEL_A_RAM;
        Sel_B  = w_run ? w_dec_sel_b  : c_SEL_B_RAM;
        Alu_Op = w_run ? w_dec_alu_op : c_ALU_ADD;
        Wr_Acc = w_run & w_dec_wr_acc;
        Wr_Ram = w_run & w_dec_wr_ram;
        Rd_Ram = w_run & w_dec_rd_ram;
    end

    assign Pc_Addr     = r_pc;
    assign Operand     = Instr[ADDR_BUS-1:0];
    assign Running     = w_run;
    assign Done        = (r_state == ST_HALTED);
    assign Cycle_Count = r_cnt;

endmodule : bip_control_unit
`default_nettype wire

// File: tb/tb_bip_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bip_control_unit
//  Description : Directed self-checking bench for bip_control_unit. A second
//                instance with a 3-bit cycle counter covers saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bip_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default widths)
    logic        reset, start;
    logic [15:0] instr;
    logic [10:0] pc_addr, operand;
    logic [1:0]  sel_a;
    logic        sel_b, alu_op, wr_acc, wr_ram, rd_ram, running, done;
    logic [15:0] cycle_count;
    logic [15:0] mem [0:2047];

    assign instr = mem[pc_addr];

    bip_control_unit #(.ADDR_BUS(11), .DATA_SIZE(16), .CNT_WIDTH(16)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Instr(instr),
        .Pc_Addr(pc_addr), .Operand(operand), .Sel_A(sel_a), .Sel_B(sel_b),
        .Alu_Op(alu_op), .Wr_Acc(wr_acc), .Wr_Ram(wr_ram), .Rd_Ram(rd_ram),
        .Running(running), .Done(done), .Cycle_Count(cycle_count)
    );

    // Saturation instance (3-bit counter)
    logic        reset2, start2;
    logic [15:0] instr2;
    logic [10:0] pc2, operand2;
    logic [1:0]  sel_a2;
    logic        sel_b2, alu_op2, wr_acc2, wr_ram2, rd_ram2, running2, done2;
    logic [2:0]  cycle_count2;
    logic [15:0] mem2 [0:2047];

    assign instr2 = mem2[pc2];

    bip_control_unit #(.ADDR_BUS(11), .DATA_SIZE(16), .CNT_WIDTH(3)) dut2 (
        .Clk(clk), .Reset(reset2), .Start(start2), .Instr(instr2),
        .Pc_Addr(pc2), .Operand(operand2), .Sel_A(sel_a2), .Sel_B(sel_b2),
        .Alu_Op(alu_op2), .Wr_Acc(wr_acc2), .Wr_Ram(wr_ram2), .Rd_Ram(rd_ram2),
        .Running(running2), .Done(done2), .Cycle_Count(cycle_count2)
    );

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [15:0] NOP_W = 16'hF800;   // opcode 11111
    localparam logic [15:0] HLT_W = 16'h0000;

    // Program: LDI 16; STO 1; LD 1; ADDI 255; STO 2; LD 16; HLT
    logic [15:0] prog [0:6];
    // Expected {Sel_A, Sel_B, Alu_Op, Wr_Acc, Wr_Ram, Rd_Ram}
    logic [6:0]  exp_strb [0:6];

    function automatic logic [6:0] strb();
        return {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 2048; i++) mem[i] = NOP_W;
        for (int i = 0; i < 7; i++) mem[i] = prog[i];
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Starts the loaded program from IDLE and checks every step to the halt
    task automatic run_prog(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (pc_addr !== 11'(k) || running !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s step%0d pc/run/done: got %0d/%b/%b want %0d/1/0",
                         tag, k, pc_addr, running, done, k);
            end
            n_cmp++;
            if (strb() !== exp_strb[k]) begin
                n_err++;
                $display("FAIL %s step%0d strobes: got %b want %b", tag, k, strb(), exp_strb[k]);
            end
            n_cmp++;
            if (operand !== prog[k][10:0] || cycle_count !== 16'(k)) begin
                n_err++;
                $display("FAIL %s step%0d operand/count: got %0d/%0d want %0d/%0d",
                         tag, k, operand, cycle_count, prog[k][10:0], k);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || running !== 1'b0 || pc_addr !== 11'd6 ||
            cycle_count !== 16'd7 || strb() !== 7'd0) begin
            n_err++;
            $display("FAIL %s halted: done=%b run=%b pc=%0d cnt=%0d strb=%b want 1 0 6 7 0",
                     tag, done, running, pc_addr, cycle_count, strb());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (pc_addr !== 11'd0 || running !== 1'b0 || done !== 1'b0 ||
                strb() !== 7'd0 || cycle_count !== 16'd0) begin
                n_err++;
                $display("FAIL reset idle%0d: pc=%0d run=%b done=%b strb=%b cnt=%0d want all 0",
                         i, pc_addr, running, done, strb(), cycle_count);
            end
            tick();
        end
    endtask

    task automatic test_program();
        pulse_reset();
        run_prog("prog");
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (done !== 1'b1 || pc_addr !== 11'd6 || cycle_count !== 16'd7 || strb() !== 7'd0) begin
                n_err++;
                $display("FAIL hold%0d: done=%b pc=%0d cnt=%0d strb=%b want 1 6 7 0",
                         i, done, pc_addr, cycle_count, strb());
            end
        end
    endtask

    task automatic test_nop();
        for (int i = 0; i < 2048; i++) mem[i] = NOP_W;
        mem[0] = 16'hFFFF;            // opcode 11111 with nonzero operand
        mem[1] = HLT_W;
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (pc_addr !== 11'd0 || running !== 1'b1 || strb() !== 7'd0 || operand !== 11'h7FF) begin
            n_err++;
            $display("FAIL nop pc0: pc=%0d run=%b strb=%b opnd=%h want 0 1 0 7ff",
                     pc_addr, running, strb(), operand);
        end
        tick();
        n_cmp++;
        if (pc_addr !== 11'd1 || running !== 1'b1 || strb() !== 7'd0) begin
            n_err++;
            $display("FAIL nop pc1: pc=%0d run=%b strb=%b want 1 1 0", pc_addr, running, strb());
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || pc_addr !== 11'd1 || cycle_count !== 16'd2) begin
            n_err++;
            $display("FAIL nop halt: done=%b pc=%0d cnt=%0d want 1 1 2", done, pc_addr, cycle_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2048; i++) mem[i] = NOP_W;
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && pc_addr !== 11'd2047; i++) tick();
        n_cmp++;
        if (pc_addr !== 11'd2047 || running !== 1'b1 || cycle_count !== 16'd2047) begin
            n_err++;
            $display("FAIL wrap top: pc=%0d run=%b cnt=%0d want 2047 1 2047",
                     pc_addr, running, cycle_count);
        end
        mem[0] = HLT_W;
        tick();
        n_cmp++;
        if (pc_addr !== 11'd0 || running !== 1'b1 || strb() !== 7'd0) begin
            n_err++;
            $display("FAIL wrap to0: pc=%0d run=%b strb=%b want 0 1 0", pc_addr, running, strb());
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || pc_addr !== 11'd0 || cycle_count !== 16'd2049) begin
            n_err++;
            $display("FAIL wrap halt: done=%b pc=%0d cnt=%0d want 1 0 2049", done, pc_addr, cycle_count);
        end
    endtask

    task automatic test_mid_reset();
        load_prog();
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (pc_addr !== 11'd3 || strb() !== exp_strb[3]) begin
            n_err++;
            $display("FAIL midrst pc3: pc=%0d strb=%b want 3 %b", pc_addr, strb(), exp_strb[3]);
        end
        reset = 1'b1;
        start = 1'b1;                 // Reset must win over Start
        tick();
        reset = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (pc_addr !== 11'd0 || running !== 1'b0 || done !== 1'b0 ||
            cycle_count !== 16'd0 || strb() !== 7'd0) begin
            n_err++;
            $display("FAIL midrst idle: pc=%0d run=%b done=%b cnt=%0d strb=%b want all 0",
                     pc_addr, running, done, cycle_count, strb());
        end
        tick();
        n_cmp++;
        if (running !== 1'b0 || pc_addr !== 11'd0) begin
            n_err++;
            $display("FAIL midrst stays idle: run=%b pc=%0d want 0 0", running, pc_addr);
        end
        run_prog("rerun");
    endtask

    task automatic test_start_ignored();
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                       // PC=1
        start = 1'b1;
        tick();                       // PC=2, Start high during RUN
        tick();
        start = 1'b0;
        n_cmp++;
        if (pc_addr !== 11'd3 || running !== 1'b1 || cycle_count !== 16'd3) begin
            n_err++;
            $display("FAIL start_in_run: pc=%0d run=%b cnt=%0d want 3 1 3", pc_addr, running, cycle_count);
        end
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (done !== 1'b1 || running !== 1'b0 || pc_addr !== 11'd6 || cycle_count !== 16'd7) begin
            n_err++;
            $display("FAIL start_in_halt: done=%b run=%b pc=%0d cnt=%0d want 1 0 6 7",
                     done, running, pc_addr, cycle_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 2048; i++) mem2[i] = NOP_W;
        mem2[10] = HLT_W;
        reset2 = 1'b1;
        start2 = 1'b0;
        tick();
        reset2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            n_cmp++;
            if (pc2 !== 11'(k) || running2 !== 1'b1 || cycle_count2 !== 3'((k < 7) ? k : 7)) begin
                n_err++;
                $display("FAIL sat step%0d: pc=%0d run=%b cnt=%0d want %0d 1 %0d",
                         k, pc2, running2, cycle_count2, k, (k < 7) ? k : 7);
            end
            tick();
        end
        n_cmp++;
        if (done2 !== 1'b1 || pc2 !== 11'd10 || cycle_count2 !== 3'd7) begin
            n_err++;
            $display("FAIL sat halt: done=%b pc=%0d cnt=%0d want 1 10 7", done2, pc2, cycle_count2);
        end
    endtask

    initial begin
        prog[0] = {5'b00011, 11'd16};     // LDI 16
        prog[1] = {5'b00001, 11'd1};      // STO 1
        prog[2] = {5'b00010, 11'd1};      // LD 1
        prog[3] = {5'b00101, 11'd255};    // ADDI 255
        prog[4] = {5'b00001, 11'd2};      // STO 2
        prog[5] = {5'b00010, 11'd16};     // LD 16
        prog[6] = {5'b00000, 11'd0};      // HLT
        exp_strb[0] = 7'b01_0_0_1_0_0;
        exp_strb[1] = 7'b00_0_0_0_1_0;
        exp_strb[2] = 7'b00_0_0_1_0_1;
        exp_strb[3] = 7'b10_1_0_1_0_0;
        exp_strb[4] = 7'b00_0_0_0_1_0;
        exp_strb[5] = 7'b00_0_0_1_0_1;
        exp_strb[6] = 7'b00_0_0_0_0_0;

        reset  = 1'b1;
        start  = 1'b0;
        reset2 = 1'b1;
        start2 = 1'b0;
        load_prog();
        for (int i = 0; i < 2048; i++) mem2[i] = NOP_W;

        test_reset();
        test_program();
        test_nop();
        test_wrap();
        test_mid_reset();
        test_start_ignored();
        test_saturate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bip_control_unit
`default_nettype wire
